// File: rtl/grad_norm_pkg.sv
// grad_norm_pkg
//   Shared constants for the gradient de-normaliser: the 5-segment
//   piecewise-linear table (TOP, lower bound, BASE, MUL per segment),
//   the Q1.10 unity value and the segment-index encoding.
//   Segment k covers SEG_LO[k] <= n <= SEG_TOP[k] (S0 uses 1024 inclusive),
//   g = SEG_BASE[k] + ((SEG_TOP[k] - n) * SEG_MUL[k]) >> FRAC_SHIFT.
package grad_norm_pkg;

  localparam int SEG_NUM = 5;
  localparam int DELTA_W = 9;   // TOP - n never exceeds 256
  localparam int MUL_W   = 6;   // largest multiplier is 32
  localparam int PROD_W  = 14;  // 256 * 32 = 8192

  localparam logic [10:0] NORM_ONE = 11'd1024;

  typedef logic [2:0] seg_t;

  // Input above 1.0 is clamped to 1.0 and flagged with this index.
  localparam seg_t SEG_CLAMP = 3'd5;

  localparam logic [10:0] SEG_TOP  [SEG_NUM] = '{11'd1024, 11'd896, 11'd768, 11'd512, 11'd256};
  localparam logic [10:0] SEG_LO   [SEG_NUM] = '{11'd896, 11'd768, 11'd512, 11'd256, 11'd0};
  localparam logic [10:0] SEG_BASE [SEG_NUM] = '{11'd0, 11'd32, 11'd96, 11'd352, 11'd864};
  localparam logic [MUL_W-1:0] SEG_MUL [SEG_NUM] = '{6'd4, 6'd8, 6'd16, 6'd32, 6'd12};

  // Multiplier for a segment; the clamp segment always has delta 0, so 0 is safe.
  function automatic logic [MUL_W-1:0] seg_mul(input seg_t s);
    case (s)
      3'd0:    return SEG_MUL[0];
      3'd1:    return SEG_MUL[1];
      3'd2:    return SEG_MUL[2];
      3'd3:    return SEG_MUL[3];
      3'd4:    return SEG_MUL[4];
      default: return '0;
    endcase
  endfunction

  // Base offset for a segment; clamped input reconstructs to 0.
  function automatic logic [10:0] seg_base(input seg_t s);
    case (s)
      3'd0:    return SEG_BASE[0];
      3'd1:    return SEG_BASE[1];
      3'd2:    return SEG_BASE[2];
      3'd3:    return SEG_BASE[3];
      3'd4:    return SEG_BASE[4];
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/grad_denorm_mul.sv
// grad_denorm_mul
//   Combinational constant multiplier: product = delta * MUL(seg), built
//   from shifted partial products selected by the bits of the segment
//   multiplier (no hard multipliers are inferred).
//   Ports:
//     delta   in  9   TOP - n from stage 1
//     seg     in  3   segment index (5 = clamp, multiplier 0)
//     product out 14  delta * MUL
module grad_denorm_mul
  import grad_norm_pkg::*;
(
  input  logic [DELTA_W-1:0] delta,
  input  seg_t               seg,
  output logic [PROD_W-1:0]  product
);

  logic [MUL_W-1:0]  mul;
  logic [PROD_W-1:0] partial [MUL_W];

  assign mul = seg_mul(seg);

  // One shifted copy of delta per set multiplier bit, e.g. 12 = (d<<3)+(d<<2).
  genvar gi;
  generate
    for (gi = 0; gi < MUL_W; gi++) begin : g_pp
      assign partial[gi] = mul[gi] ? ({{(PROD_W-DELTA_W){1'b0}}, delta} << gi) : '0;
    end
  endgenerate

  always_comb begin
    product = '0;
    for (int i = 0; i < MUL_W; i++) begin
      product = product + partial[i];
    end
  end

endmodule

// File: rtl/grad_denorm.sv
// grad_denorm
//   Reconstructs a 12-bit gradient magnitude from an 11-bit Q1.10 normalised
//   weight through a 5-segment piecewise-linear map. Three register stages
//   (decode -> multiply -> add/saturate) with valid/ready backpressure; the
//   whole pipeline freezes while the output is held.
//   Optional build macro: GRAD_DENORM_ROUND_EN -- round-half-up before the
//   final right shift instead of truncating.
//   Ports:
//     clk       in   clock
//     rst       in   asynchronous active-high reset
//     in_valid  in   norm_in valid
//     in_ready  out  input accepted this cycle (low only while stalled)
//     norm_in   in   NORM_W normalised weight, unsigned
//     out_valid out  grad_out/seg_out valid
//     out_ready in   downstream accepts this cycle
//     grad_out  out  GRAD_W reconstructed gradient
//     seg_out   out  segment used (0..4), 5 = clamped input
module grad_denorm
  import grad_norm_pkg::*;
#(
  parameter int NORM_W     = 11,
  parameter int GRAD_W     = 12,
  parameter int FRAC_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NORM_W-1:0] norm_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [GRAD_W-1:0] grad_out,
  output logic [2:0]        seg_out
);

  localparam int SUM_W = PROD_W + 1;

`ifdef GRAD_DENORM_ROUND_EN
  localparam logic [SUM_W-1:0] ROUND_ADD = SUM_W'(2 ** (FRAC_SHIFT - 1));
`else
  localparam logic [SUM_W-1:0] ROUND_ADD = '0;
`endif

  logic                s1_valid_reg, s2_valid_reg, s3_valid_reg;
  seg_t                s1_seg_reg, s2_seg_reg, s3_seg_reg;
  logic [DELTA_W-1:0]  s1_delta_reg;
  logic [PROD_W-1:0]   s2_prod_reg;
  logic [GRAD_W-1:0]   s3_grad_reg;

  seg_t                seg_next;
  logic [DELTA_W-1:0]  delta_next;
  logic [PROD_W-1:0]   prod_next;
  logic [SUM_W-1:0]    prod_adj;
  logic [SUM_W-1:0]    sum_full;
  logic [GRAD_W-1:0]   grad_next;
  logic                stall;

  // Every stage holds while the output is presented but not taken.
  assign stall    = s3_valid_reg & ~out_ready;
  assign in_ready = ~stall;

  // Stage 1 decode. Default is S4; scanning S3 down to S0 lets the highest
  // matching segment win, which is the top-down first-match rule. The delta
  // fits in 9 bits, so the subtraction is done modulo 512.
  always_comb begin
    seg_next   = seg_t'(SEG_NUM - 1);
    delta_next = SEG_TOP[SEG_NUM-1][DELTA_W-1:0] - norm_in[DELTA_W-1:0];
    for (int i = SEG_NUM - 2; i >= 0; i--) begin
      if (norm_in >= SEG_LO[i]) begin
        seg_next   = seg_t'(i);
        delta_next = SEG_TOP[i][DELTA_W-1:0] - norm_in[DELTA_W-1:0];
      end
    end
    if (norm_in > NORM_ONE) begin
      seg_next   = SEG_CLAMP;
      delta_next = '0;
    end
  end

  // Stage 2 multiply.
  grad_denorm_mul u_mul (
    .delta   (s1_delta_reg),
    .seg     (s1_seg_reg),
    .product (prod_next)
  );

  // Stage 3 add base, optional rounding, saturate to the output width.
  always_comb begin
    prod_adj  = {1'b0, s2_prod_reg} + ROUND_ADD;
    sum_full  = {{(SUM_W-11){1'b0}}, seg_base(s2_seg_reg)} + (prod_adj >> FRAC_SHIFT);
    grad_next = (|sum_full[SUM_W-1:GRAD_W]) ? '1 : sum_full[GRAD_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
      s1_seg_reg   <= '0;
      s2_seg_reg   <= '0;
      s3_seg_reg   <= '0;
      s1_delta_reg <= '0;
      s2_prod_reg  <= '0;
      s3_grad_reg  <= '0;
    end else if (!stall) begin
      // in_ready is high here, so in_valid alone marks an input transfer.
      s1_valid_reg <= in_valid;
      s2_valid_reg <= s1_valid_reg;
      s3_valid_reg <= s2_valid_reg;
      s1_seg_reg   <= seg_next;
      s1_delta_reg <= delta_next;
      s2_seg_reg   <= s1_seg_reg;
      s2_prod_reg  <= prod_next;
      s3_seg_reg   <= s2_seg_reg;
      s3_grad_reg  <= grad_next;
    end
  end

  assign out_valid = s3_valid_reg;
  assign grad_out  = s3_grad_reg;
  assign seg_out   = s3_seg_reg;

endmodule

// File: tb/tb_grad_denorm.sv
// tb_grad_denorm
//   Directed bench for grad_denorm: reset state, latency, a table of
//   hand-computed vectors streamed back-to-back, a mid-stream output stall,
//   and reset with items in flight. Expected rounding result follows
//   GRAD_DENORM_ROUND_EN.
module tb_grad_denorm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] norm_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] grad_out;
  logic [2:0]  seg_out;

  always #5 clk = ~clk;

  grad_denorm dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .norm_in   (norm_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grad_out  (grad_out),
    .seg_out   (seg_out)
  );

  typedef struct {
    logic [10:0] n;
    logic [11:0] g;
    logic [2:0]  s;
  } vec_t;

  typedef struct {
    logic [11:0] g;
    logic [2:0]  s;
    int          cyc;
  } obs_t;

`ifdef GRAD_DENORM_ROUND_EN
  localparam logic [11:0] EXP_1022 = 12'd1;
`else
  localparam logic [11:0] EXP_1022 = 12'd0;
`endif

  localparam int NV = 14;

  vec_t        vecs [NV];
  obs_t        got [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          idx;
  int          stall_n;
  logic        acc;
  logic        prev_stall;
  logic [11:0] held_g;
  logic [2:0]  held_s;

  always @(posedge clk) cyc <= cyc + 1;

  // Output transfer monitor: sampled mid-cycle, a transfer occurs at the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got.push_back('{g: grad_out, s: seg_out, cyc: cyc});
      $display("out xfer: grad=%0d seg=%0d cyc=%0d", grad_out, seg_out, cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{11'd1024, 12'd0,    3'd0};
    vecs[1]  = '{11'd800,  12'd80,   3'd1};
    vecs[2]  = '{11'd600,  12'd264,  3'd2};
    vecs[3]  = '{11'd300,  12'd776,  3'd3};
    vecs[4]  = '{11'd100,  12'd981,  3'd4};
    vecs[5]  = '{11'd896,  12'd32,   3'd0};
    vecs[6]  = '{11'd895,  12'd32,   3'd1};
    vecs[7]  = '{11'd768,  12'd96,   3'd1};
    vecs[8]  = '{11'd512,  12'd352,  3'd2};
    vecs[9]  = '{11'd256,  12'd864,  3'd3};
    vecs[10] = '{11'd0,    12'd1056, 3'd4};
    vecs[11] = '{11'd2047, 12'd0,    3'd5};
    vecs[12] = '{11'd1022, EXP_1022, 3'd0};
    vecs[13] = '{11'd1023, 12'd0,    3'd0};

    // Reset held with a valid input present.
    rst = 1'b1; in_valid = 1'b1; norm_in = 11'd900; out_ready = 1'b1;
    repeat (3) begin
      tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_grad", grad_out, 0);
      check("rst_seg", seg_out, 0);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check("in_ready_after_rst", in_ready, 1);

    // Latency: one input, output valid on the third cycle.
    in_valid = 1'b1; norm_in = 11'd900;
    tick();
    in_valid = 1'b0;
    check("lat_cycle1_valid", out_valid, 0);
    tick();
    check("lat_cycle2_valid", out_valid, 0);
    tick();
    check("lat_cycle3_valid", out_valid, 1);
    check("lat_900_grad", grad_out, 31);
    check("lat_900_seg", seg_out, 0);
    repeat (3) tick();
    got.delete();

    // Table streamed back-to-back with out_ready held high.
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; norm_in = vecs[i].n;
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    check("tbl_count", got.size(), NV);
    for (int i = 0; i < NV && i < got.size(); i++) begin
      check($sformatf("tbl_grad[n=%0d]", vecs[i].n), got[i].g, vecs[i].g);
      check($sformatf("tbl_seg[n=%0d]", vecs[i].n), got[i].s, vecs[i].s);
      if (i > 0) check($sformatf("tbl_consecutive[%0d]", i), got[i].cyc, got[0].cyc + i);
    end

    // Backpressure: 10 items, out_ready low for cycles 4..7.
    got.delete(); idx = 0; stall_n = 0; prev_stall = 1'b0; held_g = '0; held_s = '0;
    for (int c = 0; c < 40 && (idx < 10 || got.size() < 10); c++) begin
      out_ready = !(c >= 4 && c <= 7);
      in_valid  = (idx < 10);
      norm_in   = vecs[idx].n;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && !out_ready) begin
        stall_n++;
        check("bp_in_ready_low", in_ready, 0);
        if (prev_stall) begin
          check("bp_grad_hold", grad_out, held_g);
          check("bp_seg_hold", seg_out, held_s);
        end
        held_g = grad_out; held_s = seg_out; prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    check("bp_all_accepted", idx, 10);
    check("bp_stall_cycles", stall_n, 4);
    check("bp_count", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      check($sformatf("bp_grad[%0d]", i), got[i].g, vecs[i].g);
      check($sformatf("bp_seg[%0d]", i), got[i].s, vecs[i].s);
    end

    // Reset with three items in flight.
    got.delete(); out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; norm_in = vecs[i+1].n;
      tick();
    end
    in_valid = 1'b0;
    check("mid_valid_before_rst", out_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_grad", grad_out, 0);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    tick();
    check("post_rst_idle_valid", out_valid, 0);
    in_valid = 1'b1; norm_in = 11'd512;
    tick();
    in_valid = 1'b0;
    check("post_rst_c1_valid", out_valid, 0);
    tick();
    check("post_rst_c2_valid", out_valid, 0);
    tick();
    check("post_rst_c3_valid", out_valid, 1);
    check("post_rst_grad", grad_out, 352);
    check("post_rst_seg", seg_out, 2);
    repeat (4) tick();
    check("post_rst_count", got.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
